// File: rtl/output_port_allocator_pkg.sv
// Shared types for the virtual channel router output port allocator.
// Holds the two-state packet-lock FSM encoding.
package vr_alloc_pkg;

  typedef enum logic {
    ALLOC_IDLE   = 1'b0,
    ALLOC_LOCKED = 1'b1
  } alloc_state_t;

endpackage

// File: rtl/output_port_allocator_if.sv
// Request/grant/credit bundle between the input requesters and one output port allocator.
// The master side presents requests and credits; the slave side is the allocator.
interface output_port_allocator_if #(
  parameter int NUM_REQS    = 5,
  parameter int NUM_CREDITS = 4,
  parameter int CREDIT_W    = $clog2(NUM_CREDITS + 1)
);

  logic [NUM_REQS-1:0] requests;
  logic [NUM_REQS-1:0] tails;
  logic                credit_in;
  logic [NUM_REQS-1:0] grants;
  logic                locked;
  logic [CREDIT_W-1:0] credits;

  modport master (
    output requests, tails, credit_in,
    input  grants, locked, credits
  );

  modport slave (
    input  requests, tails, credit_in,
    output grants, locked, credits
  );

endinterface

// File: rtl/output_port_allocator_rr_priority_select.sv
// Rotating-priority selector: first set request at or after ptr, wrapping.
// The pointer is owned by the caller so it only advances on packet completion.
module rr_priority_select #(
  parameter int NUM_REQS = 5,
  parameter int IDX_W    = $clog2(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] requests,
  input  logic [IDX_W-1:0]    ptr,
  output logic [NUM_REQS-1:0] winner_oh,
  output logic [IDX_W-1:0]    winner_idx
);

  int  cand;
  logic found;

  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    found      = 1'b0;
    cand       = 0;
    for (int off = 0; off < NUM_REQS; off++) begin
      cand = (int'(ptr) + off) % NUM_REQS;
      if (!found && requests[cand]) begin
        found             = 1'b1;
        winner_oh[cand]   = 1'b1;
        winner_idx        = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/output_port_allocator.sv
// Per-output-port switch allocator: round-robin with packet lock, gated by downstream credits.
// Grants are combinational from registered state; all state moves on the rising clk edge.
module output_port_allocator
  import vr_alloc_pkg::*;
#(
  parameter int NUM_REQS    = 5,
  parameter int NUM_CREDITS = 4,
  localparam int CREDIT_W   = $clog2(NUM_CREDITS + 1),
  localparam int IDX_W      = $clog2(NUM_REQS)
) (
  input logic                    clk,
  input logic                    reset,
  output_port_allocator_if.slave bus
);

  alloc_state_t        fsm;
  logic [IDX_W-1:0]    owner;
  logic [IDX_W-1:0]    ptr;
  logic [CREDIT_W-1:0] credits;

  logic [NUM_REQS-1:0] sel_oh;
  logic [IDX_W-1:0]    sel_idx;
  logic [NUM_REQS-1:0] grants_c;
  logic                fire;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQS - 1)) ? '0 : i + 1'b1;
  endfunction

  rr_priority_select #(
    .NUM_REQS(NUM_REQS),
    .IDX_W   (IDX_W)
  ) u_select (
    .requests  (bus.requests),
    .ptr       (ptr),
    .winner_oh (sel_oh),
    .winner_idx(sel_idx)
  );

  // While locked only the owner may traverse; nothing moves without a registered credit.
  always_comb begin
    grants_c = '0;
    if (!reset && credits != '0) begin
      if (fsm == ALLOC_IDLE) begin
        grants_c = sel_oh;
      end else if (bus.requests[owner]) begin
        grants_c[owner] = 1'b1;
      end
    end
  end

  assign fire       = |grants_c;
  assign bus.grants = grants_c;
  assign bus.locked = !reset && (fsm == ALLOC_LOCKED);
  assign bus.credits = credits;

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm     <= ALLOC_IDLE;
      owner   <= '0;
      ptr     <= '0;
      credits <= CREDIT_W'(NUM_CREDITS);
    end else begin
      case (fsm)
        ALLOC_IDLE: begin
          if (fire) begin
            if (bus.tails[sel_idx]) begin
              ptr <= next_idx(sel_idx);
            end else begin
              fsm   <= ALLOC_LOCKED;
              owner <= sel_idx;
            end
          end
        end
        ALLOC_LOCKED: begin
          if (fire && bus.tails[owner]) begin
            fsm <= ALLOC_IDLE;
            ptr <= next_idx(owner);
          end
        end
        default: fsm <= ALLOC_IDLE;
      endcase

      // A returned credit at full count is a downstream protocol error; hold at the ceiling.
      if (fire && !bus.credit_in) begin
        credits <= credits - CREDIT_W'(1);
      end else if (!fire && bus.credit_in && credits != CREDIT_W'(NUM_CREDITS)) begin
        credits <= credits + CREDIT_W'(1);
      end
    end
  end

  grants_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(grants_c));

  credit_overflow: assert property (@(posedge clk) disable iff (reset)
    !(bus.credit_in && !fire && credits == CREDIT_W'(NUM_CREDITS)))
    else $warning("credit_in received while credit count is already full");

endmodule

// File: tb/tb_output_port_allocator.sv
// Randomised and directed bench for output_port_allocator against a behavioural model.
// The model tracks lock/owner/pointer/credits as plain integers.
module tb_output_port_allocator;

  localparam int N  = 5;
  localparam int NC = 4;

  logic clk;
  logic reset;

  output_port_allocator_if #(.NUM_REQS(N), .NUM_CREDITS(NC)) bus ();

  output_port_allocator #(
    .NUM_REQS   (N),
    .NUM_CREDITS(NC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  int m_locked;
  int m_owner;
  int m_ptr;
  int m_cred;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Expected grant index from the allocation rules, -1 when nothing traverses.
  function automatic int model_winner(input logic [N-1:0] r, input logic rst);
    if (rst || m_cred == 0) return -1;
    if (m_locked != 0) return r[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] t, input logic c, input logic rst);
    int w;
    logic [N-1:0] exp_g;
    bus.requests  = r;
    bus.tails     = t;
    bus.credit_in = c;
    reset         = rst;
    #2;
    w = model_winner(r, rst);
    exp_g = '0;
    if (w >= 0) exp_g[w] = 1'b1;
    checkOutput("grants", 32'(bus.grants), 32'(exp_g));
    checkOutput("locked", 32'(bus.locked), (rst || m_locked == 0) ? 32'd0 : 32'd1);
    checkOutput("credits", 32'(bus.credits), 32'(m_cred));
    @(posedge clk);
    #1;
    if (rst) begin
      m_locked = 0;
      m_owner  = 0;
      m_ptr    = 0;
      m_cred   = NC;
    end else begin
      if (w >= 0) begin
        if (t[w]) begin
          m_locked = 0;
          m_ptr    = (w + 1) % N;
        end else begin
          m_locked = 1;
          m_owner  = w;
        end
      end
      m_cred = m_cred - ((w >= 0) ? 1 : 0) + (c ? 1 : 0);
      if (m_cred > NC) m_cred = NC;
    end
  endtask

  initial begin
    logic [N-1:0] rr;
    logic [N-1:0] tt;
    logic         cc;
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    bus.requests  = '0;
    bus.tails     = '0;
    bus.credit_in = 1'b0;
    m_locked = 0; m_owner = 0; m_ptr = 0; m_cred = NC;
    @(posedge clk);
    #1;
    applyStimulus(5'b00000, 5'b00000, 1'b0, 1'b1);
    applyStimulus(5'b10110, 5'b11111, 1'b0, 1'b1);

    $display("[TB] round robin over single-flit packets");
    repeat (4) applyStimulus(5'b10110, 5'b11111, 1'b1, 1'b0);
    checkOutput("t1_credits", 32'(bus.credits), 32'd4);

    $display("[TB] packet lock on req0");
    applyStimulus(5'b00011, 5'b00000, 1'b1, 1'b0);
    applyStimulus(5'b00011, 5'b00000, 1'b1, 1'b0);
    applyStimulus(5'b00011, 5'b00001, 1'b1, 1'b0);
    applyStimulus(5'b00011, 5'b00010, 1'b1, 1'b0);

    $display("[TB] credit exhaustion");
    repeat (6) applyStimulus(5'b00001, 5'b00000, 1'b0, 1'b0);
    checkOutput("t3_credits_empty", 32'(bus.credits), 32'd0);
    applyStimulus(5'b00001, 5'b00000, 1'b1, 1'b0);
    checkOutput("t3_credits_one", 32'(bus.credits), 32'd1);
    applyStimulus(5'b00001, 5'b00000, 1'b0, 1'b0);
    applyStimulus(5'b00001, 5'b00001, 1'b1, 1'b0);
    applyStimulus(5'b00001, 5'b00001, 1'b1, 1'b0);
    repeat (3) applyStimulus(5'b00000, 5'b00000, 1'b1, 1'b0);
    checkOutput("t3_credits_refill", 32'(bus.credits), 32'd4);

    $display("[TB] owner bubble");
    applyStimulus(5'b00100, 5'b00000, 1'b1, 1'b0);
    repeat (3) applyStimulus(5'b01000, 5'b00000, 1'b0, 1'b0);
    applyStimulus(5'b01100, 5'b00100, 1'b1, 1'b0);
    applyStimulus(5'b01100, 5'b11111, 1'b1, 1'b0);

    $display("[TB] simultaneous fire and credit return");
    applyStimulus(5'b00001, 5'b00001, 1'b0, 1'b0);
    applyStimulus(5'b00001, 5'b00001, 1'b0, 1'b0);
    checkOutput("t5_credits_two", 32'(bus.credits), 32'd2);
    applyStimulus(5'b00001, 5'b00001, 1'b1, 1'b0);
    checkOutput("t5_credits_hold", 32'(bus.credits), 32'd2);

    $display("[TB] reset mid-packet");
    applyStimulus(5'b00010, 5'b00000, 1'b0, 1'b0);
    checkOutput("t6_locked", 32'(bus.locked), 32'd1);
    checkOutput("t6_credits_one", 32'(bus.credits), 32'd1);
    applyStimulus(5'b00010, 5'b00000, 1'b0, 1'b1);
    checkOutput("t6_credits_restored", 32'(bus.credits), 32'd4);
    applyStimulus(5'b00000, 5'b00000, 1'b1, 1'b0);
    checkOutput("t6_credits_saturate", 32'(bus.credits), 32'd4);
    applyStimulus(5'b11111, 5'b11111, 1'b0, 1'b0);

    $display("[TB] randomised traffic");
    for (int i = 0; i < 400; i++) begin
      rr = N'($urandom);
      tt = N'($urandom);
      cc = ($urandom_range(0, 1) == 1) && (m_cred < NC);
      applyStimulus(rr, tt, cc, $urandom_range(0, 59) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
